// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: turns level-sensitive read/write requests from the SLC-3
// control unit into timed asynchronous-SRAM strobes, returns read data to
// the MDR mux and pulses Mem_Rdy once per completed access.
// Optional feature macro: MEM_IO_HEX_EN -- address 16'hFFFF becomes a
// memory-mapped port (reads return Switches, writes load HEX_reg).
module mem_io_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_out,
  input  logic [15:0] Switches,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Rdy,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_oe,
  output logic [19:0] ADDR,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic        UB_N,
  output logic        LB_N,
  output logic [15:0] HEX_reg
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Counter value on the last strobe-active cycle of an SRAM access.
  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_io;
  logic [15:0] r_dcpu;
  logic        r_rdy;
  logic [15:0] r_wdata;
  logic        r_doe;
  logic [19:0] r_addr;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_ub_n;
  logic        r_lb_n;
  logic        w_io_addr;

`ifdef MEM_IO_HEX_EN
  logic [15:0] r_hex;

  assign w_io_addr = (MAR == 16'hFFFF);

  // Hex display register, loaded on the single cycle of an I/O write.
  // The latched write data is used so a request that drops early still
  // shows the value that was presented when the access started.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_hex <= 16'h0000;
    end else if ((r_state == ST_WRITE) && r_io) begin
      r_hex <= r_wdata;
    end else begin
      r_hex <= r_hex;
    end
  end

  assign HEX_reg = r_hex;
`else
  assign w_io_addr = 1'b0;
  assign HEX_reg   = 16'h0000;
`endif

  // Access FSM: request decode, wait counting, strobe generation, capture.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_io    <= 1'b0;
      r_dcpu  <= 16'h0000;
      r_rdy   <= 1'b0;
      r_wdata <= 16'h0000;
      r_doe   <= 1'b0;
      r_addr  <= 20'h00000;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Write wins when both requests are high.
          if (Mem_WE) begin
            r_addr  <= {4'h0, MAR};
            r_wdata <= MDR_out;
            r_cnt   <= 4'd0;
            r_io    <= w_io_addr;
            r_state <= ST_WRITE;
            if (!w_io_addr) begin
              r_ce_n <= 1'b0;
              r_we_n <= 1'b0;
              r_ub_n <= 1'b0;
              r_lb_n <= 1'b0;
              r_doe  <= 1'b1;
            end
          end else if (Mem_OE) begin
            r_addr  <= {4'h0, MAR};
            r_cnt   <= 4'd0;
            r_io    <= w_io_addr;
            r_state <= ST_READ;
            if (!w_io_addr) begin
              r_ce_n <= 1'b0;
              r_oe_n <= 1'b0;
              r_ub_n <= 1'b0;
              r_lb_n <= 1'b0;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (!Mem_OE) begin
            // Aborted read: release the bus without touching Data_to_CPU.
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_io) begin
            r_dcpu  <= Switches;
            r_rdy   <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_cnt == LP_LAST) begin
            r_dcpu  <= Data_from_SRAM;
            r_rdy   <= 1'b1;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_WRITE: begin
          // Writes always run to completion once started.
          if (r_io || (r_cnt == LP_LAST)) begin
            r_rdy   <= 1'b1;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_doe   <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          if (Mem_OE || Mem_WE) begin
            r_state <= ST_RELEASE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          // Hold here until the request is dropped so it cannot retrigger.
          if (!Mem_OE && !Mem_WE) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RELEASE;
          end
        end
        default: begin
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_ub_n  <= 1'b1;
          r_lb_n  <= 1'b1;
          r_doe   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Data_to_CPU  = r_dcpu;
  assign Mem_Rdy      = r_rdy;
  assign Data_to_SRAM = r_wdata;
  assign Data_oe      = r_doe;
  assign ADDR         = r_addr;
  assign CE_N         = r_ce_n;
  assign OE_N         = r_oe_n;
  assign WE_N         = r_we_n;
  assign UB_N         = r_ub_n;
  assign LB_N         = r_lb_n;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: cycle-table bench for mem_io_ctrl (WAIT_CYCLES=2) with a
// behavioural asynchronous SRAM, plus hand-written I/O-port sequences.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_oe = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mar = 16'h0000;
  logic [15:0] mdr = 16'h0000;
  logic [15:0] sw = 16'h0000;
  logic [15:0] d_from_sram;
  logic [15:0] d_to_cpu;
  logic        rdy;
  logic [15:0] d_to_sram;
  logic        doe;
  logic [19:0] addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0] hex;

  logic [15:0] mem [0:65535];
  int          wr20 = 0;
  int          n_pass = 0;
  int          n_total = 0;

  mem_io_ctrl #(.WAIT_CYCLES(2)) dut (
    .Clk(clk), .Reset(rst_n), .Mem_OE(mem_oe), .Mem_WE(mem_we),
    .MAR(mar), .MDR_out(mdr), .Switches(sw), .Data_from_SRAM(d_from_sram),
    .Data_to_CPU(d_to_cpu), .Mem_Rdy(rdy), .Data_to_SRAM(d_to_sram),
    .Data_oe(doe), .ADDR(addr), .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n),
    .UB_N(ub_n), .LB_N(lb_n), .HEX_reg(hex)
  );

  always #5 clk = ~clk;

  // SRAM read side: valid data only while the chip is selected for reading.
  assign d_from_sram = (!ce_n && !oe_n) ? mem[addr[15:0]] : 16'hDEAD;

  // SRAM write side: store on every clock with an active write strobe.
  always @(posedge clk) begin
    if (!ce_n && !we_n && doe) begin
      mem[addr[15:0]] <= d_to_sram;
      if (addr == 20'h00020) wr20 <= wr20 + 1;
    end
  end

  typedef struct {
    logic        rst_n, oe, we;
    logic [15:0] mar, mdr;
    logic        rdy, ce_n, oe_n, we_n, doe;
    logic [19:0] addr;
    logic [15:0] dcpu, dsram;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic o, logic w, logic [15:0] a, logic [15:0] d,
                              logic e_rdy, logic e_ce, logic e_oe, logic e_we, logic e_doe,
                              logic [19:0] e_addr, logic [15:0] e_dcpu, logic [15:0] e_dsram);
    vec_t v;
    v.rst_n = r; v.oe = o; v.we = w; v.mar = a; v.mdr = d;
    v.rdy = e_rdy; v.ce_n = e_ce; v.oe_n = e_oe; v.we_n = e_we; v.doe = e_doe;
    v.addr = e_addr; v.dcpu = e_dcpu; v.dsram = e_dsram;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  // Apply inputs, clock once, sample just after the edge.
  task automatic step(logic o, logic w, logic [15:0] a, logic [15:0] d, logic [15:0] s);
    mem_oe = o; mem_we = w; mar = a; mdr = d; sw = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0040] = 16'h1111;

    // reset
    vecs.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00000,16'h0000,16'h0000));
    // read 0x0010, two strobe cycles, capture at edge 3
    vecs.push_back(mk(1,1,0,16'h0010,16'h0000, 0,0,0,1,0, 20'h00010,16'h0000,16'h0000));
    vecs.push_back(mk(1,1,0,16'h0010,16'h0000, 0,0,0,1,0, 20'h00010,16'h0000,16'h0000));
    vecs.push_back(mk(1,1,0,16'h0010,16'h0000, 1,1,1,1,0, 20'h00010,16'hBEEF,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00010,16'hBEEF,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00010,16'hBEEF,16'h0000));
    // write 0x0020 with Mem_WE held six cycles
    vecs.push_back(mk(1,0,1,16'h0020,16'h1234, 0,0,1,0,1, 20'h00020,16'hBEEF,16'h1234));
    vecs.push_back(mk(1,0,1,16'h0020,16'h1234, 0,0,1,0,1, 20'h00020,16'hBEEF,16'h1234));
    vecs.push_back(mk(1,0,1,16'h0020,16'h1234, 1,1,1,1,0, 20'h00020,16'hBEEF,16'h1234));
    vecs.push_back(mk(1,0,1,16'h0020,16'h1234, 0,1,1,1,0, 20'h00020,16'hBEEF,16'h1234));
    vecs.push_back(mk(1,0,1,16'h0020,16'h1234, 0,1,1,1,0, 20'h00020,16'hBEEF,16'h1234));
    vecs.push_back(mk(1,0,1,16'h0020,16'h1234, 0,1,1,1,0, 20'h00020,16'hBEEF,16'h1234));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00020,16'hBEEF,16'h1234));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00020,16'hBEEF,16'h1234));
    // both requests high: write path, OE_N stays high
    vecs.push_back(mk(1,1,1,16'h0030,16'h5678, 0,0,1,0,1, 20'h00030,16'hBEEF,16'h5678));
    vecs.push_back(mk(1,1,1,16'h0030,16'h5678, 0,0,1,0,1, 20'h00030,16'hBEEF,16'h5678));
    vecs.push_back(mk(1,1,1,16'h0030,16'h5678, 1,1,1,1,0, 20'h00030,16'hBEEF,16'h5678));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00030,16'hBEEF,16'h5678));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00030,16'hBEEF,16'h5678));
    // read aborted after one strobe cycle: no capture, no Mem_Rdy
    vecs.push_back(mk(1,1,0,16'h0040,16'h0000, 0,0,0,1,0, 20'h00040,16'hBEEF,16'h5678));
    vecs.push_back(mk(1,0,0,16'h0040,16'h0000, 0,1,1,1,0, 20'h00040,16'hBEEF,16'h5678));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00040,16'hBEEF,16'h5678));
    // reset in the middle of a write
    vecs.push_back(mk(1,0,1,16'h0050,16'h9999, 0,0,1,0,1, 20'h00050,16'hBEEF,16'h9999));
    vecs.push_back(mk(0,0,1,16'h0050,16'h9999, 0,1,1,1,0, 20'h00000,16'h0000,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,1,1,0, 20'h00000,16'h0000,16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      step(vecs[i].oe, vecs[i].we, vecs[i].mar, vecs[i].mdr, 16'h0000);
      chk("Mem_Rdy",      i, 32'(rdy),       32'(vecs[i].rdy));
      chk("CE_N",         i, 32'(ce_n),      32'(vecs[i].ce_n));
      chk("OE_N",         i, 32'(oe_n),      32'(vecs[i].oe_n));
      chk("WE_N",         i, 32'(we_n),      32'(vecs[i].we_n));
      chk("UB_N",         i, 32'(ub_n),      32'(vecs[i].ce_n));
      chk("LB_N",         i, 32'(lb_n),      32'(vecs[i].ce_n));
      chk("Data_oe",      i, 32'(doe),       32'(vecs[i].doe));
      chk("ADDR",         i, 32'(addr),      32'(vecs[i].addr));
      chk("Data_to_CPU",  i, 32'(d_to_cpu),  32'(vecs[i].dcpu));
      chk("Data_to_SRAM", i, 32'(d_to_sram), 32'(vecs[i].dsram));
      chk("HEX_reg",      i, 32'(hex),       32'h0000_0000);
    end

    chk("sram_0020", 0, 32'(mem[16'h0020]), 32'h0000_1234);
    chk("sram_0030", 0, 32'(mem[16'h0030]), 32'h0000_5678);
    chk("writes_to_0020", 0, 32'(wr20), 32'd2);

`ifdef MEM_IO_HEX_EN
    // I/O write: one WRITE cycle, no strobes, HEX_reg loaded at DONE entry
    step(1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000);
    chk("hex_wr_ce_n", 1, 32'(ce_n), 32'd1);
    chk("hex_wr_doe",  1, 32'(doe),  32'd0);
    chk("hex_wr_rdy",  1, 32'(rdy),  32'd0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("hex_wr_rdy",  2, 32'(rdy),  32'd1);
    chk("hex_wr_ce_n", 2, 32'(ce_n), 32'd1);
    chk("hex_reg",     2, 32'(hex),  32'h0000_A5A5);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("hex_wr_rdy",  3, 32'(rdy),  32'd0);
    // I/O read: Switches returned with Mem_Rdy at the second edge
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    chk("hex_rd_ce_n", 1, 32'(ce_n), 32'd1);
    chk("hex_rd_oe_n", 1, 32'(oe_n), 32'd1);
    chk("hex_rd_rdy",  1, 32'(rdy),  32'd0);
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    chk("hex_rd_rdy",  2, 32'(rdy),      32'd1);
    chk("hex_rd_data", 2, 32'(d_to_cpu), 32'h0000_00FF);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("hex_rd_rdy",  3, 32'(rdy),  32'd0);
    chk("hex_reg",     3, 32'(hex),  32'h0000_A5A5);
`else
    // Without the I/O port, 0xFFFF is an ordinary SRAM location
    step(1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000);
    chk("ffff_wr_ce_n", 1, 32'(ce_n), 32'd0);
    chk("ffff_wr_we_n", 1, 32'(we_n), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("ffff_wr_rdy",  2, 32'(rdy),  32'd0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("ffff_wr_rdy",  3, 32'(rdy),  32'd1);
    chk("hex_reg",      3, 32'(hex),  32'h0000_0000);
    chk("sram_ffff",    3, 32'(mem[16'hFFFF]), 32'h0000_A5A5);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    chk("ffff_rd_oe_n", 1, 32'(oe_n), 32'd0);
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    chk("ffff_rd_rdy",  2, 32'(rdy),  32'd0);
    step(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    chk("ffff_rd_rdy",  3, 32'(rdy),      32'd0);
    chk("ffff_rd_data", 3, 32'(d_to_cpu), 32'h0000_0000);
    // held request completes at edge 3 with SRAM data, not Switches
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF);
    chk("ffff_rd_rdy",  4, 32'(rdy),      32'd1);
    chk("ffff_rd_data", 4, 32'(d_to_cpu), 32'h0000_A5A5);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
